// File: rtl/ofifo_pkg.sv
// ofifo_pkg: default ring parameters and the pointer width helper shared by the FIFO lanes.
package ofifo_pkg;
  localparam int COL = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH = 16;
  localparam int AFULL_TH = 14;
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/ofifo_col.sv
// ofifo_col: single-lane circular buffer with wrap-bit pointers and a fall-through head word.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic                      pop,
  input  logic [psum_bw-1:0]        din,
  output logic [psum_bw-1:0]        dout,
  output logic                      empty,
  output logic                      full,
  output logic [ptr_w(depth)-1:0]   occ
);
  localparam int pw = ptr_w(depth);
  localparam int aw = pw - 1;
  logic [pw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [psum_bw-1:0] mem_q [depth];
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]) && (wr_ptr_q[aw] != rd_ptr_q[aw]);
  assign occ = wr_ptr_q - rd_ptr_q;
  assign dout = mem_q[rd_ptr_q[aw-1:0]];
  always_comb begin
    wr_ptr_d = wr_ptr_q + pw'(wr & ~full);
    rd_ptr_d = rd_ptr_q + pw'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage keeps stale words across reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr && !full) mem_q[wr_ptr_q[aw-1:0]] <= din;
  end
endmodule

// File: rtl/ofifo_ring.sv
// ofifo_ring: per-column output FIFOs popped row-aligned; OFIFO_ERR_EN enables a sticky o_err
// on dropped writes and ignored reads.
module ofifo_ring
  import ofifo_pkg::*;
#(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth = DEPTH,
  parameter int afull_th = AFULL_TH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [col*psum_bw-1:0]    in,
  input  logic [col-1:0]            wr,
  input  logic                      rd,
  output logic [col*psum_bw-1:0]    out,
  output logic                      o_full,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic                      o_afull,
  output logic [ptr_w(depth)-1:0]   o_count,
  output logic                      o_err
);
  localparam int pw = ptr_w(depth);
  logic [col-1:0] empty_v, full_v;
  logic [pw-1:0] occ [col];
  logic pop;
  assign o_valid = ~|empty_v;
  assign o_full = |full_v;
  assign o_ready = ~o_full;
  assign pop = rd & o_valid;
  for (genvar i = 0; i < col; i++) begin : g_col
    ofifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .pop   (pop),
      .din   (in[i*psum_bw +: psum_bw]),
      .dout  (out[i*psum_bw +: psum_bw]),
      .empty (empty_v[i]),
      .full  (full_v[i]),
      .occ   (occ[i])
    );
  end
  // Row count follows the slowest lane; almost-full follows the fastest.
  always_comb begin
    o_count = occ[0];
    o_afull = 1'b0;
    for (int k = 0; k < col; k++) begin
      o_count = occ[k] < o_count ? occ[k] : o_count;
      o_afull = o_afull | (occ[k] >= pw'(afull_th));
    end
  end
`ifdef OFIFO_ERR_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (|(wr & full_v)) | (rd & ~o_valid);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_ofifo_ring.sv
// tb_ofifo_ring: directed and random traffic against a per-lane queue model of the FIFO ring.
module tb_ofifo_ring;
  localparam int C = 8;
  localparam int W = 16;
  localparam int D = 16;
  localparam int TH = 14;
  logic clk = 0;
  logic reset;
  logic [C*W-1:0] in;
  logic [C-1:0] wr;
  logic rd;
  logic [C*W-1:0] out;
  logic o_full, o_ready, o_valid, o_afull, o_err;
  logic [$clog2(D):0] o_count;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q [C][$];
  bit err_m = 0;

  ofifo_ring #(.col(C), .psum_bw(W), .depth(D), .afull_th(TH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_full(o_full), .o_ready(o_ready), .o_valid(o_valid), .o_afull(o_afull),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int mn = D + 1;
    bit af = 0, fu = 0, v = 1;
    for (int i = 0; i < C; i++) begin
      int sz = q[i].size();
      if (sz < mn) mn = sz;
      af |= sz >= TH;
      fu |= sz == D;
      v &= sz > 0;
    end
    chk("o_valid", o_valid, v);
    chk("o_full", o_full, fu);
    chk("o_ready", o_ready, !fu);
    chk("o_afull", o_afull, af);
    chk("o_count", o_count, mn);
`ifdef OFIFO_ERR_EN
    chk("o_err", o_err, err_m);
`else
    chk("o_err", o_err, 0);
`endif
    if (v) for (int i = 0; i < C; i++) chk($sformatf("out%0d", i), out[i*W +: W], q[i][0]);
  endtask

  task automatic model(input logic [C-1:0] w, input logic r, input logic [C*W-1:0] d);
    bit v = 1;
    bit fpre [C];
    for (int i = 0; i < C; i++) begin
      v &= q[i].size() > 0;
      fpre[i] = q[i].size() == D;
    end
    if (r && !v) err_m = 1;
    for (int i = 0; i < C; i++) if (w[i] && fpre[i]) err_m = 1;
    if (r && v) for (int i = 0; i < C; i++) void'(q[i].pop_front());
    for (int i = 0; i < C; i++) if (w[i] && !fpre[i]) q[i].push_back(d[i*W +: W]);
  endtask

  task automatic step(input logic [C-1:0] w, input logic r, input logic [C*W-1:0] d);
    wr = w;
    rd = r;
    in = d;
    @(posedge clk);
    model(w, r, d);
    #1;
    check_all();
  endtask

  function automatic logic [C*W-1:0] row(input int r);
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = W'(r * 16 + i);
    return v;
  endfunction

  function automatic logic [C*W-1:0] rnd();
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < C; i++) q[i].delete();
    err_m = 0;
  endtask

  initial begin
    reset = 1; wr = '0; rd = 0; in = '0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    #1 check_all();
    for (int r = 0; r < 3; r++) step('1, 0, row(r));
    for (int r = 0; r < 4; r++) step('0, 1, '0);
    for (int k = 0; k < D + 1; k++) step(8'h01, 0, row(k));
    for (int k = 0; k < D; k++) step(8'hFE, 0, row(k + 40));
    step('1, 1, row(99));
    for (int k = 0; k < D; k++) step('0, 1, '0);
    step('1, 0, rnd());
    step('1, 0, rnd());
    for (int k = 0; k < 40; k++) step('1, 1, rnd());
    for (int k = 0; k < 400; k++) begin
      logic r;
      r = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(C'($urandom), r, rnd());
    end
    for (int k = 0; k < 5; k++) step('1, 0, rnd());
    #2 reset = 1;
    clear_model();
    #1 check_all();
    #1 reset = 0;
    step('1, 0, row(7));
    step('0, 0, '0);
    step('0, 1, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofifo_ring.md
Name: ofifo_ring

Overview:
- Parametrised output FIFO between the systolic array's per-column psum outputs and the SFU/readout path.
- Each of `col` columns owns an independent circular buffer of `depth` words, written by its own `wr[i]` strobe.
- Reads are row-aligned: one `rd` pops one word from every column at once, allowed only when all columns hold data.
- Adds over the prior generation: configurable depth, an occupancy count, an almost-full flag, and optional error reporting.

Parameters:
- col, 8, number of array columns / FIFO lanes
- psum_bw, 16, width of one psum word
- depth, 16, entries per column; power of two, >= 4
- afull_th, 14, occupancy at or above which a column is almost-full; 1 <= afull_th <= depth

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  col*psum_bw  psum words; lane i is in[(i+1)*psum_bw-1 : i*psum_bw]
- wr  input  col  per-column write strobe
- rd  input  1  row-aligned pop request
- out  output  col*psum_bw  head word of every column (first-word-fall-through), same lane packing as in
- o_full  output  1  any column full
- o_ready  output  1  no column full (= ~o_full)
- o_valid  output  1  every column non-empty
- o_afull  output  1  any column occupancy >= afull_th
- o_count  output  $clog2(depth)+1  minimum occupancy across columns (= number of complete rows)
- o_err  output  1  sticky error flag; tied 0 unless OFIFO_ERR_EN is defined

Behaviour:
- Reset, asserted asynchronously:
  - all read/write pointers cleared to 0.
  - o_full=0, o_ready=1, o_valid=0, o_afull=0, o_count=0, o_err=0.
  - Storage is not reset.
  - Reset mid-operation discards all contents immediately; the first write after deassertion lands in entry 0.
- Pointers:
  - each column has wr_ptr and rd_ptr of $clog2(depth)+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low bits equal and wrap bits differ.
  - occupancy = wr_ptr - rd_ptr, taken modulo 2^($clog2(depth)+1).
- Write:
  - on a clk edge with wr[i]=1 and column i not full, store lane i at wr_ptr[i] and increment it.
  - wr[i] to a full column is dropped and its pointers are unchanged.
- Read:
  - on a clk edge with rd=1 and o_valid=1, increment every column's rd_ptr.
  - rd with o_valid=0 is ignored and no pointer moves.
- Simultaneous write and pop on one column:
  - both take effect; occupancy is unchanged.
  - The full check uses pre-edge state, so a write to a column that is full at the edge is dropped even if a pop occurs on the same edge.
- out:
  - combinational from storage at each rd_ptr (zero-latency head).
  - Contents are meaningful only while o_valid=1.
  - A written word is visible on out the cycle after its write edge.
- Flags and o_count are combinational from pointer state, so they update the cycle after the causing edge.
- Wrap-around: pointers roll over naturally at 2^($clog2(depth)+1); no special handling is needed.
- Lanes may fill unevenly. o_count reflects the slowest lane, o_afull and o_full reflect the fastest.

Optional Feature:
- Macro: OFIFO_ERR_EN.
- Defined:
  - o_err sets on any dropped write (wr[i]=1 while column i is full) or ignored read (rd=1 while o_valid=0).
  - o_err stays set until reset.
- Undefined:
  - o_err is constant 0 and no error logic is synthesised.
  - Drop and ignore behaviour is otherwise identical.

Decomposition:
- Package ofifo_pkg holds:
  - the default parameter constants (COL, PSUM_BW, DEPTH, AFULL_TH).
  - a function computing pointer width from depth.
- Sub-module ofifo_col: a single-lane circular buffer.
  - Contains storage, pointers, empty/full/occupancy outputs and a FWFT head.
  - Inputs: clk, reset, wr, pop, din.
  - ofifo_ring instantiates col copies, drives a shared pop = rd & o_valid, and reduces flags and the minimum occupancy.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_full=0, o_count=0, o_afull=0.
- Write 3 rows with wr=8'hFF, lane i of row r = 16'h(r*16+i) -> o_count=3, o_valid=1, out lane 5 = 16'h0005. Then pop 3 -> out lanes return 0x10+i and 0x20+i in order, and o_valid=0 after the third pop.
- wr=8'h01 sixteen times (depth 16) -> o_full=1, o_ready=0, o_afull=1, o_valid=0, o_count=0. A 17th write is dropped (o_err=1 with OFIFO_ERR_EN).
- Fill all lanes to 16, then assert wr=8'hFF and rd=1 on the same edge -> pop occurs, writes are dropped, o_count=15.
- Steady stream of 40 write+pop pairs at occupancy 2 -> data order preserved across two pointer wraps and o_count stays at 2.
- Assert reset asynchronously with o_count=5 -> outputs return to reset values before the next clk edge, and the next row written is read back first.
